// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset vector, major opcodes and
// the fetch front-end state encoding.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between the memory response path and decode.
// Push, pop and flush may all occur in one cycle; flush takes priority.
// Storage is not reset: only pointers and the count are control state.
module fetch_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              full;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // Entry storage, written on push only.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= wdata;
    end

    // The credit scheme upstream must never push into a full queue without a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction fetch front end: PC, credit-limited memory requests,
// response discard after redirects, and the instruction queue toward decode.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
    parameter int              FIFO_DEPTH = 2,
    parameter int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_req,
    output logic            misalign_err,
    output logic            halted
);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rsp_pc;
    logic [XLEN-1:0]       redirect_pc;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      outstanding_nxt;
    logic [CNT_W-1:0]      discard;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W:0]        in_use;
    logic                  credit_ok;
    logic                  fire;
    logic                  rsp_ok;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic [2*XLEN-1:0]     head;

    // Credits cover both queued words and requests whose data is still in flight.
    assign in_use      = {1'b0, occupancy} + {1'b0, outstanding};
    assign credit_ok   = (in_use < (CNT_W + 1)'(FIFO_DEPTH));
    assign redirect_pc = {redirect_target[XLEN-1:2], 2'b00};
    assign imem_addr   = pc;
    assign fire        = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is left over from before a reset.
    assign rsp_ok      = imem_rsp_valid && (outstanding != '0);
    assign push        = rsp_ok && (discard == '0) && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign halted      = (state == FS_HALT);

    assign instr_valid = !empty;
    assign instr       = instr_valid ? head[XLEN-1:0]      : '0;
    assign instr_pc    = instr_valid ? head[2*XLEN-1:XLEN] : '0;
    assign instr_pc4   = instr_pc + XLEN'(4);

    // In-flight count after this cycle's accept and response.
    always_comb begin
        outstanding_nxt = outstanding;
        if (fire && !rsp_ok)      outstanding_nxt = outstanding + CNT_W'(1);
        else if (!fire && rsp_ok) outstanding_nxt = outstanding - CNT_W'(1);
    end

    // Fetch FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FS_BOOT;
        else        state <= state_nxt;
    end

    // Next state and request valid; a redirect always returns to RUN and blocks requests that cycle.
    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        case (state)
            FS_BOOT: state_nxt = FS_RUN;
            FS_RUN: begin
                imem_req_valid = credit_ok && !redirect_valid;
                if (redirect_valid) state_nxt = FS_RUN;
                else if (halt_req)  state_nxt = FS_HALT;
            end
            FS_HALT: begin
                if (redirect_valid) state_nxt = FS_RUN;
            end
            default: state_nxt = FS_BOOT;
        endcase
    end

    // PC, response PC, in-flight/discard counters and the misalignment pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            rsp_pc       <= RESET_PC;
            outstanding  <= '0;
            discard      <= '0;
            misalign_err <= 1'b0;
        end else begin
            outstanding  <= outstanding_nxt;
            misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
            if (redirect_valid) begin
                pc      <= redirect_pc;
                rsp_pc  <= redirect_pc;
                discard <= outstanding_nxt;
            end else begin
                if (fire) pc <= pc + XLEN'(4);
                if (push) rsp_pc <= rsp_pc + XLEN'(4);
                if (rsp_ok && (discard != '0)) discard <= discard - CNT_W'(1);
            end
        end
    end

    fetch_queue #(
        .DATA_W (2 * XLEN),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({rsp_pc, imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .empty (empty),
        .count (occupancy)
    );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end for the RV32 core. Produces the instruction stream whose opcode field drives the main decoder.
- Holds the PC and issues word requests to instruction memory through a valid/ready request channel and an in-order response channel.
- Buffers returned words in a small queue and presents them to decode with a valid/ready handshake.
- Takes redirects (taken branch, jal) from execute, and halts on a decoder request.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction queue entries (power of 2, ≥2); also the cap on outstanding requests plus queued words.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy, outstanding and discard counters.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  read data valid (in order, ≥1 cycle after accept)
- imem_rdata  in  32  instruction word
- instr_valid  out  1  queue head valid toward decode
- instr_ready  in  1  decode consumes head
- instr  out  32  head instruction (instr[6:0] = op)
- instr_pc  out  32  PC of head instruction
- instr_pc4  out  32  instr_pc + 4
- redirect_valid  in  1  taken branch/jump, one-cycle pulse
- redirect_target  in  32  new PC
- halt_req  in  1  stop fetching (illegal op / ecall)
- misalign_err  out  1  one-cycle pulse: redirect target[1:0] != 0
- halted  out  1  high in state HALT

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_PC; queue empty; outstanding=0; discard=0; state=BOOT.
  - imem_req_valid=0, instr_valid=0, misalign_err=0, halted=0.
  - imem_addr=RESET_PC, instr/instr_pc=0, instr_pc4=4.
- FSM states and transitions:
  - BOOT: one cycle, no requests, then RUN.
  - RUN: imem_req_valid=1 when occupancy+outstanding < FIFO_DEPTH and redirect_valid=0. imem_addr=pc.
  - RUN→HALT on halt_req (no redirect in the same cycle).
  - HALT: imem_req_valid=0. Responses still drain and are enqueued or discarded. halted=1.
  - HALT→RUN on redirect_valid only. Redirect wins over a simultaneous halt_req.
- Request fire = imem_req_valid & imem_req_ready. On fire: pc += 4 (wraps mod 2^32), outstanding += 1.
- Response handling:
  - imem_rsp_valid decrements outstanding. Fire and response in the same cycle leave it unchanged.
  - If discard>0, the response is dropped and discard -= 1. Otherwise it is pushed with its PC, held in a per-request PC shadow FIFO or derived from a next-response-PC register.
  - imem_rsp_valid with outstanding==0 is ignored (stale after reset).
- Queue:
  - instr_valid = !empty; head fields come straight from storage.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle are both allowed, including when full.
  - The credit rule guarantees no push into a full queue; overflow is an assertion failure.
- Fetch-to-decode latency:
  - Empty queue: instr_valid rises the cycle after imem_rsp_valid.
  - Minimum redirect-to-new-instruction latency is 3 cycles with 1-cycle memory.
- Redirect (edge where redirect_valid=1):
  - Queue flushed; a same-cycle pop is void.
  - pc = {redirect_target[31:2],2'b00}.
  - discard = outstanding + fire − rsp_valid (all in-flight requests, including one accepted this cycle).
  - misalign_err=1 for one cycle if redirect_target[1:0]!=0.
  - No request is issued in the redirect cycle. Requests resume next cycle even while discard>0.
- Back-to-back redirects: the latest target wins; discard accumulates per the same formula.
- Reset mid-operation: all state returns to reset values immediately. Late responses are dropped by the outstanding==0 rule.

Decomposition:
- Shared package core_pkg: XLEN=32, RESET_VECTOR, opcode constants (OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_R 7'b0110011, OP_BRANCH 7'b1100011, OP_IMM 7'b0010011, OP_JAL 7'b1101111), fetch FSM state enum.
- Sub-module: fetch_queue, a synchronous FIFO with parameterised width and depth and same-cycle push/pop/flush. It stores {pc, instr} (64 bits).

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning 32'h00000013 → requests at 0x0, 0x4, 0x8…; instr_valid from cycle 3 with instr_pc 0x0, 0x4 in order.
- instr_ready=0 for 10 cycles → exactly FIFO_DEPTH requests issued, then imem_req_valid=0; releasing instr_ready resumes with no lost or duplicated PCs.
- 2-cycle memory, redirect to 0x100 while 2 requests are in flight → both responses dropped; first instr_pc after redirect is 0x100, queue flushed.
- Redirect target 0x102 → misalign_err pulses once; next fetch address 0x100.
- halt_req in RUN → requests stop, in-flight word still delivered, halted=1; redirect to 0x40 → RUN, fetch from 0x40.
- PC at 0xFFFF_FFFC → next request 0x0000_0000; rst_n asserted with 1 outstanding → outputs reset at once; the late imem_rsp_valid is ignored.
